// File: rtl/acu_serial_tx.sv
// Serial transmitter for the accumulator data path: takes a word over a
// valid/ready handshake and sends it as start bit, LSB-first data, stop bit.
module acu_serial_tx #(
   parameter int SIZE         = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            send_valid,
   output logic            send_ready,
   input  logic [SIZE-1:0] data_in,
   output logic            tx,
   output logic            busy,
   output logic            done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (SIZE > 1) ? $clog2(SIZE + 1) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SIZE - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [BAUD_W-1:0] baud_q,  baud_d;
   logic [BIT_W-1:0]  bit_q,   bit_d;
   logic [SIZE-1:0]   shift_q, shift_d;
   logic              tx_q,    tx_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;
   logic              baudEnd;

   assign baudEnd    = (baud_q == BAUD_LAST);
   assign send_ready = (state_q == S_IDLE);
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign done       = done_q;

   // Next-state logic; tx/busy are derived from the next state so the
   // registered outputs line up with the state they describe.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (send_valid) begin
               state_d = S_START;
               baud_d  = '0;
               bit_d   = '0;
               shift_d = data_in;
            end
         end
         S_START: begin
            if (baudEnd) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baudEnd) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_STOP: begin
            if (baudEnd) begin
               baud_d  = '0;
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase

      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Reset aborts any frame in flight without producing a done pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_acu_serial_tx.sv
// Directed and randomized bench for acu_serial_tx, checked against a
// frame-level model of start/data/stop bit timing.
module tb_acu_serial_tx;

   localparam int SIZE  = 8;
   localparam int CPB   = 4;
   localparam int FRAME = (SIZE + 2) * CPB;

   logic            clk;
   logic            rstn;
   logic            send_valid;
   logic            send_ready;
   logic [SIZE-1:0] data_in;
   logic            tx;
   logic            busy;
   logic            done;

   int assertCount  = 0;
   int failureCount = 0;
   int cycle        = 0;
   int done1        = 0;
   int done2        = 0;

   acu_serial_tx #(.SIZE(SIZE), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .send_valid (send_valid),
      .send_ready (send_ready),
      .data_in    (data_in),
      .tx         (tx),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Expected line level for serial bit position idx of a frame carrying d.
   function automatic logic frameBit(input logic [SIZE-1:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx > SIZE) return 1'b1;
      return ((d >> (idx - 1)) & 1) != 0;
   endfunction

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failureCount++;
         $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cycle, obs, exp);
      end
   endtask

   // mode 0: drop valid after accept, 1: scribble data_in during frame,
   // 2: pulse a second request mid-frame, 3: keep valid held throughout.
   task automatic applyStimulus(input logic [SIZE-1:0] d, input int mode, output int doneCycle);
      send_valid = 1'b1;
      data_in    = d;
      checkOutput("ready_before_accept", {7'd0, send_ready}, 8'd1);
      @(posedge clk);
      for (int k = 0; k < FRAME; k++) begin
         @(negedge clk);
         checkOutput("tx_bit",   {7'd0, tx},         {7'd0, frameBit(d, k / CPB)});
         checkOutput("busy_mid", {7'd0, busy},       8'd1);
         checkOutput("done_mid", {7'd0, done},       8'd0);
         checkOutput("rdy_mid",  {7'd0, send_ready}, 8'd0);
         if (k == 0 && mode != 3) send_valid = 1'b0;
         if (mode == 1) data_in = 8'hFF;
         if (mode == 2 && k == 12) begin
            send_valid = 1'b1;
            data_in    = 8'h55;
         end
         if (mode == 2 && k == 16) send_valid = 1'b0;
      end
      @(negedge clk);
      checkOutput("done_pulse", {7'd0, done},       8'd1);
      checkOutput("busy_done",  {7'd0, busy},       8'd0);
      checkOutput("rdy_done",   {7'd0, send_ready}, 8'd1);
      checkOutput("tx_idle",    {7'd0, tx},         8'd1);
      doneCycle = cycle;
   endtask

   initial begin
      int dc;
      logic [SIZE-1:0] r;
      send_valid = 1'b0;
      data_in    = '0;
      rstn       = 1'b1;
      #1 rstn = 1'b0;
      #1;
      checkOutput("rst_tx",    {7'd0, tx},         8'd1);
      checkOutput("rst_ready", {7'd0, send_ready}, 8'd1);
      checkOutput("rst_busy",  {7'd0, busy},       8'd0);
      checkOutput("rst_done",  {7'd0, done},       8'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      $display("[TB] single frame 0xA5");
      applyStimulus(8'hA5, 0, dc);
      @(negedge clk);
      checkOutput("done_once", {7'd0, done}, 8'd0);

      $display("[TB] data hold 0x3C");
      applyStimulus(8'h3C, 1, dc);
      @(negedge clk);

      $display("[TB] ignore while busy");
      applyStimulus(8'hC3, 2, dc);
      repeat (3) begin
         @(negedge clk);
         checkOutput("no_second_frame", {7'd0, busy}, 8'd0);
         checkOutput("idle_tx",         {7'd0, tx},   8'd1);
      end

      $display("[TB] back-to-back 0x01 then 0x80");
      applyStimulus(8'h01, 3, done1);
      applyStimulus(8'h80, 0, done2);
      checkOutput("b2b_spacing", 8'(done2 - done1), 8'd41);
      @(negedge clk);

      $display("[TB] random frames");
      for (int i = 0; i < 4; i++) begin
         r = SIZE'($urandom);
         applyStimulus(r, 0, dc);
         repeat (1 + $urandom_range(0, 2)) @(negedge clk);
      end

      $display("[TB] reset mid-frame");
      r = SIZE'($urandom);
      send_valid = 1'b1;
      data_in    = r;
      @(posedge clk);
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         send_valid = 1'b0;
         checkOutput("pre_rst_tx", {7'd0, tx}, {7'd0, frameBit(r, k / CPB)});
      end
      rstn = 1'b0;
      #1;
      checkOutput("midrst_tx",    {7'd0, tx},         8'd1);
      checkOutput("midrst_busy",  {7'd0, busy},       8'd0);
      checkOutput("midrst_ready", {7'd0, send_ready}, 8'd1);
      checkOutput("midrst_done",  {7'd0, done},       8'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("post_rst_done", {7'd0, done}, 8'd0);
         checkOutput("post_rst_busy", {7'd0, busy}, 8'd0);
      end
      applyStimulus(8'h0F, 0, dc);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failureCount);
      $finish;
   end

endmodule
